// File: rtl/note_sequencer.sv
// Melody player: walks a step table and writes each note code to the audio controller over AW/W/B.
// start -> first AWVALID/WVALID in 2 cycles; valids wait on READY, a stop never aborts a started write.
module note_sequencer #(
  parameter int         NUM_STEPS      = 8,
  parameter int         IDX_W          = 3,
  parameter int         TICKS_PER_BEAT = 1000,
  parameter logic [3:0] NOTE_ADDR      = 4'h0
) (
  input  logic             clk,
  input  logic             ARESET,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [IDX_W-1:0] step_idx,
  input  logic [6:0]       step_note,
  input  logic [7:0]       step_len,
  output logic [3:0]       AWADDR,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [6:0]       WDATA,
  output logic             WVALID,
  input  logic             WREADY,
  input  logic             BVALID,
  output logic             BREADY,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WRITE, RESP, HOLD, SILENCE_W, SILENCE_R
  } state_t;

  state_t            state;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              stop_q;
  logic              aw_ok;
  logic              w_ok;
  logic              stop_pend;
  logic              aw_hs_done;
  logic              w_hs_done;

  // A stop arriving on the very cycle a decision is made counts as already latched.
  assign stop_pend  = stop_q | stop;
  assign aw_hs_done = aw_ok | (AWVALID & AWREADY);
  assign w_hs_done  = w_ok | (WVALID & WREADY);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (ARESET) begin
      state    <= IDLE;
      step_idx <= '0;
      AWADDR   <= '0;
      WDATA    <= '0;
      AWVALID  <= 1'b0;
      WVALID   <= 1'b0;
      BREADY   <= 1'b0;
      done     <= 1'b0;
      stop_q   <= 1'b0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
      tick_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          stop_q <= 1'b0;
          if (start) begin
            state    <= FETCH;
            step_idx <= '0;
          end
        end

        FETCH: begin
          stop_q  <= stop_pend;
          len_q   <= (step_len == 8'd0) ? 8'd1 : step_len;
          AWADDR  <= NOTE_ADDR;
          WDATA   <= step_note;
          AWVALID <= 1'b1;
          WVALID  <= 1'b1;
          aw_ok   <= 1'b0;
          w_ok    <= 1'b0;
          state   <= WRITE;
        end

        WRITE, SILENCE_W: begin
          if (state == WRITE) stop_q <= stop_pend;
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_ok   <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_ok   <= 1'b1;
          end
          if (aw_hs_done && w_hs_done) begin
            BREADY <= 1'b1;
            state  <= (state == WRITE) ? RESP : SILENCE_R;
          end
        end

        RESP: begin
          stop_q <= stop_pend;
          if (BVALID && BREADY) begin
            BREADY <= 1'b0;
            if (stop_pend) begin
              AWADDR  <= NOTE_ADDR;
              WDATA   <= 7'd0;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              aw_ok   <= 1'b0;
              w_ok    <= 1'b0;
              state   <= SILENCE_W;
            end else begin
              beat_cnt <= len_q - 8'd1;
              tick_cnt <= TICK_LAST;
              state    <= HOLD;
            end
          end
        end

        // Each beat spends TICKS_PER_BEAT cycles; the final tick of the final beat decides what follows.
        HOLD: begin
          if (stop_pend || (tick_cnt == '0 && beat_cnt == 8'd0 && step_idx >= LAST_IDX && !loop)) begin
            AWADDR  <= NOTE_ADDR;
            WDATA   <= 7'd0;
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
            state   <= SILENCE_W;
          end else if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end else if (beat_cnt != 8'd0) begin
            beat_cnt <= beat_cnt - 8'd1;
            tick_cnt <= TICK_LAST;
          end else if (step_idx < LAST_IDX) begin
            step_idx <= step_idx + IDX_W'(1);
            state    <= FETCH;
          end else begin
            step_idx <= '0;
            state    <= FETCH;
          end
        end

        SILENCE_R: begin
          if (BVALID && BREADY) begin
            BREADY   <= 1'b0;
            done     <= 1'b1;
            step_idx <= '0;
            stop_q   <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- AXI-lite-style write master that plays a melody by writing note codes into the audio controller's note register.
- Sits directly upstream of the audio controller's AW/W/B write channel, in place of the free-running test master.
- Steps through an externally supplied step table (note plus duration) and holds each note for a timed number of beats.
- Supports one-shot and looping playback, and writes silence (note 0) when playback ends or is stopped.

Parameters:
- NUM_STEPS, 8: number of melody steps in the table. Must be at least 2.
- IDX_W, 3: width of step_idx. Must satisfy 2^IDX_W >= NUM_STEPS.
- TICKS_PER_BEAT, 1000: clk cycles per beat. Must be at least 1.
- NOTE_ADDR, 4'h0: AWADDR value used for every note write.

Ports:
- clk, input, 1: single clock; everything is rising-edge.
- ARESET, input, 1: synchronous, active-high reset.
- start, input, 1: start playback at step 0; accepted only in IDLE.
- stop, input, 1: request stop; sticky until serviced.
- loop, input, 1: sampled at the last step; 1 means wrap to step 0.
- step_idx, output, IDX_W: index of the step currently being fetched or played.
- step_note, input, 7: note code for step_idx; combinational table lookup.
- step_len, input, 8: duration of the step in beats; 0 is treated as 1.
- AWADDR, output, 4: write address.
- AWVALID, output, 1: write-address valid.
- AWREADY, input, 1: write-address ready.
- WDATA, output, 7: write data (note code).
- WVALID, output, 1: write-data valid.
- WREADY, input, 1: write-data ready.
- BVALID, input, 1: write-response valid.
- BREADY, output, 1: write-response ready.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when returning to IDLE.

Behaviour:
- Reset (ARESET high at a clk edge), including mid-transaction:
  - State goes to IDLE; step_idx=0, AWADDR=0, WDATA=0, AWVALID=0, WVALID=0, BREADY=0, busy=0, done=0.
  - Stop latch and counters are cleared.
  - An in-flight transaction is abandoned without completing it.
- State machine: IDLE, FETCH, WRITE, RESP, HOLD, SILENCE_W, SILENCE_R.
- IDLE:
  - start=1 goes to FETCH with step_idx=0.
  - stop is ignored in IDLE and the latch is cleared.
- FETCH (1 cycle): latch step_note and step_len(0 becomes 1), then go to WRITE.
- WRITE:
  - AWVALID and WVALID rise on the same cycle; AWADDR=NOTE_ADDR and WDATA=latched note are held stable.
  - Each valid drops on the cycle after its own handshake (VALID&READY at an edge). The channels are independent and may complete in either order or together.
  - Once both handshakes are done, go to RESP.
- RESP:
  - BREADY=1.
  - On BVALID&BREADY, go to HOLD and load the beat and tick counters.
- HOLD:
  - Lasts exactly step_len*TICKS_PER_BEAT cycles.
  - Then, if the stop latch is set, go to SILENCE_W.
  - Else, if step_idx < NUM_STEPS-1, increment step_idx and go to FETCH.
  - Else (last step), if loop=1, set step_idx=0 and go to FETCH; otherwise go to SILENCE_W.
- SILENCE_W / SILENCE_R:
  - Same handshake rules as WRITE/RESP, with WDATA=0.
  - After the response, go to IDLE with done=1 for one cycle and step_idx=0.
- stop while busy:
  - Latched.
  - Never aborts a started AXI transaction: WRITE/RESP run to completion and then go to SILENCE_W instead of HOLD.
  - In HOLD, stop cuts the hold short on the next cycle.
  - In SILENCE states, stop has no further effect.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: start wins, and stop is ignored.
- Latency: start sampled at edge N gives FETCH at N+1 and AWVALID=WVALID=1 from N+2.
- The hold counter is wide enough for 255*TICKS_PER_BEAT and does not wrap.

Test Plan:
- Basic play: NUM_STEPS=3, TICKS_PER_BEAT=4, notes {10,20,30}, lens {1,2,1}, slave always ready with BVALID one cycle after W, loop=0.
  - Required: writes 10, 20, 30, 0 at AWADDR 0.
  - Required: HOLD lengths of 4, 8 and 4 cycles.
  - Required: done pulses once and busy falls.
- Skewed handshakes: AWREADY delayed 3 cycles, WREADY immediate.
  - Required: WVALID drops after 1 cycle, AWVALID is held with AWADDR stable until accepted.
  - Required: BREADY rises only after both handshakes complete.
- Loop: loop=1.
  - Required: after step 2, step_idx goes to 0 and note 10 is rewritten.
  - Required: no silence write and no done pulse.
- Stop mid-HOLD on step 1, then stop mid-WRITE with BVALID delayed 5 cycles.
  - Required (HOLD case): next transaction is WDATA=0, then IDLE.
  - Required (WRITE case): the pending write completes with its note, then WDATA=0 is written, then done pulses.
- Zero length and start while busy: step_len=0 on a step.
  - Required: that step's HOLD lasts exactly 4 cycles.
  - Required: a start pulse during HOLD causes no change.
- Reset mid-RESP: ARESET high for 1 cycle.
  - Required: all outputs 0 on the next cycle and state IDLE.
  - Required: a subsequent start plays from step 0.
